cpm_reg_pipe: RTL and testbench
===============================

# cpm_reg_pipe

Parametrised, elastic successor to the single clear/enable register in the CPM datapath. It is a DEPTH-stage pipeline register with a per-stage valid bit, a valid/ready handshake on both sides, and bubble collapsing: an empty stage is filled even while downstream is stalled. It also has a global Enable (stall), a synchronous Clear (flush and preload) and an occupancy count. It sits between CPM producer/consumer stages that need registered, back-pressurable transport instead of a bare enable register.

## Interface
- DW, 8, data width in bits (≥1)
- DEPTH, 2, number of register stages (≥1)
- RST_DAT, 0, value every data register takes on reset
- CW, $clog2(DEPTH+1), width of Count (derived, not overridden)

- Clk  input  1  single clock, rising edge
- Rst  input  1  asynchronous, active-high reset
- Clear  input  1  synchronous flush; priority over everything except Rst
- DataClr  input  DW  value loaded into every data register on Clear
- Enable  input  1  global advance enable; 0 freezes all state
- InValid  input  1  upstream data valid
- InReady  output  1  block can accept DataIn this cycle
- DataIn  input  DW  upstream data
- OutValid  output  1  DataOut valid
- OutReady  input  1  downstream accepts DataOut
- DataOut  output  DW  data of stage DEPTH-1
- Count  output  CW  number of valid stages

## Operation
- State: data register d[i] and valid bit v[i] for each stage i=0..DEPTH-1. Stage 0 is the input; stage DEPTH-1 drives DataOut.
- Accept chain (combinational): acc[DEPTH]=OutReady; acc[i]=~v[i] | acc[i+1].
- InReady = Enable & ~Clear & acc[0]. OutValid = Enable & ~Clear & v[DEPTH-1].
- Input transfer = InValid & InReady. Output transfer = OutValid & OutReady.
- Edge update with Enable=1 and Clear=0, for each stage i with acc[i]=1:
  - v[i] takes the source valid: InValid for i=0, v[i-1] otherwise.
  - d[i] loads the source data (DataIn or d[i-1]) only when the source valid is 1.
  - Otherwise d[i] holds its value.
- Stages with acc[i]=0 hold both v and d.
- Enable=0: all v and d hold; InReady=0 and OutValid=0.
- Clear=1 (any Enable): all v←0 and all d←DataClr on the next edge. No transfer is accepted in that cycle, because InReady and OutValid are forced low.
- Count = popcount(v), registered through v. No extra logic is permitted to skew it.
- DataOut = d[DEPTH-1] at all times. When OutValid=0 it shows the last loaded, DataClr or RST_DAT value.
- DEPTH=1 gives a single handshaked register with full throughput: InReady = Enable & ~Clear & (~v[0] | OutReady).

## Timing
- Reset (async on Rst high, released synchronously by the integrator) sets:
  - v=0, d=RST_DAT, Count=0
  - InReady = Enable & ~Clear; OutValid=0; DataOut=RST_DAT
- Latency: a word accepted on edge k appears with OutValid=1 after edge k+DEPTH-1, provided no stall occurs. This is DEPTH cycles from the accepting cycle to the cycle it can be taken.
- Throughput: one word per cycle sustained while OutReady=1 and Enable=1.
- Full: all v=1 and OutReady=0 gives InReady=0. Simultaneous output and input transfer is allowed when full and OutReady=1, and Count is unchanged.
- Empty: OutValid=0 and InReady=Enable & ~Clear, regardless of OutReady.
- Bubble collapse: with OutReady=0, a new word advances into the lowest-indexed empty stages until it meets an occupied stage.
- Clear and Rst mid-stream discard all in-flight words. No partial output transfer occurs.
- Clear with Enable=0 still flushes. Clear asserted for several cycles holds the block empty.

## Test plan
- DW=8, DEPTH=3: reset, then stream 0x01..0x05 with OutReady=1 -> first OutValid 3 cycles after the 0x01 accept; outputs 0x01..0x05 back to back; Count peaks at 3.
- DEPTH=3: OutReady=0, push 0xA0,0xA1,0xA2 -> InReady drops after the 3rd accept and Count=3. Then OutReady=1 with InValid=1 and DataIn=0xA3 -> pop 0xA0 and accept 0xA3 in the same cycle; Count stays 3.
- DEPTH=3: one word 0x5A, OutReady=0 -> 0x5A reaches stage 2 after 2 edges (bubble collapse). Push 0x5B -> it lands in stage 1 and Count=2.
- Enable=0 for 4 cycles mid-stream holding 0x10,0x11 -> InReady=0, OutValid=0, v/d/Count frozen. On resume the order is preserved: 0x10 then 0x11.
- Clear=1 with DataClr=0xFF while 2 words are in flight and InValid=1 -> next cycle Count=0, DataOut=0xFF, no word accepted or delivered.
- Rst pulse while full, then DEPTH=1 bench -> Count=0, DataOut=RST_DAT immediately. DEPTH=1 streams 1 word/cycle with 1-cycle latency.

Source files
------------

// File: rtl/cpm_reg_pipe.sv
// Elastic DEPTH-stage register pipe with per-stage valid; a word is takeable DEPTH cycles after its accept.
// OutReady back-pressure ripples down the accept chain, but empty stages keep filling while stalled.
module cpm_reg_pipe #(
   parameter int DW = 8,
   parameter int DEPTH = 2,
   parameter logic [DW-1:0] RST_DAT = '0,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic          Clear,
   input  logic [DW-1:0] DataClr,
   input  logic          Enable,
   input  logic          InValid,
   output logic          InReady,
   input  logic [DW-1:0] DataIn,
   output logic          OutValid,
   input  logic          OutReady,
   output logic [DW-1:0] DataOut,
   output logic [CW-1:0] Count
);

   logic [DW-1:0]    d [DEPTH];
   logic [DEPTH-1:0] v;
   logic [DEPTH-1:0] acc;
   logic [DEPTH-1:0] src_v;
   logic [DW-1:0]    src_d [DEPTH];
   logic             run;

   assign run = Enable & ~Clear;

   // A stage can accept when it or any stage after it has a hole, or the
   // output drains; written flat so the chain has no combinational self-loop.
   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      assign acc[i] = OutReady | ~(&v[DEPTH-1:i]);
      if (i == 0) begin : g_head
         assign src_v[i] = InValid;
         assign src_d[i] = DataIn;
      end else begin : g_body
         assign src_v[i] = v[i-1];
         assign src_d[i] = d[i-1];
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         v <= '0;
         for (int i = 0; i < DEPTH; i++) d[i] <= RST_DAT;
      end else if (Clear) begin
         v <= '0;
         for (int i = 0; i < DEPTH; i++) d[i] <= DataClr;
      end else if (Enable) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (acc[i]) begin
               v[i] <= src_v[i];
               if (src_v[i]) d[i] <= src_d[i];
            end
         end
      end
   end

   always_comb begin
      Count = '0;
      for (int i = 0; i < DEPTH; i++) Count = Count + CW'(v[i]);
   end

   assign InReady  = run & acc[0];
   assign OutValid = run & v[DEPTH-1];
   assign DataOut  = d[DEPTH-1];

endmodule

// File: tb/tb_cpm_reg_pipe.sv
// Bench for cpm_reg_pipe: a DEPTH=3 and a DEPTH=1 instance, directed stimulus, queue scoreboards.
module tb_cpm_reg_pipe;

   logic       Clk = 1'b0;
   logic       Rst;
   // DEPTH=3 instance
   logic       clr, en, iv, ir, ov, ordy;
   logic [7:0] dclr, din, dout;
   logic [1:0] cnt;
   // DEPTH=1 instance
   logic       clr1, en1, iv1, ir1, ov1, ordy1;
   logic [7:0] dclr1, din1, dout1;
   logic [0:0] cnt1;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] q3[$];
   logic [7:0] q1[$];
   logic [7:0] exp3, exp1;

   always #5 Clk = ~Clk;

   cpm_reg_pipe #(.DW(8), .DEPTH(3), .RST_DAT(8'h3C)) u3 (
      .Clk(Clk), .Rst(Rst), .Clear(clr), .DataClr(dclr), .Enable(en),
      .InValid(iv), .InReady(ir), .DataIn(din),
      .OutValid(ov), .OutReady(ordy), .DataOut(dout), .Count(cnt)
   );

   cpm_reg_pipe #(.DW(8), .DEPTH(1), .RST_DAT(8'hC3)) u1 (
      .Clk(Clk), .Rst(Rst), .Clear(clr1), .DataClr(dclr1), .Enable(en1),
      .InValid(iv1), .InReady(ir1), .DataIn(din1),
      .OutValid(ov1), .OutReady(ordy1), .DataOut(dout1), .Count(cnt1)
   );

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
      end
   endtask

   // Output monitors: every output transfer must match the next queued word.
   always @(negedge Clk) begin
      if (ov && ordy) begin
         if (q3.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL d3_extra_out: got 0x%0h required no transfer", dout);
         end else begin
            exp3 = q3.pop_front();
            chk("d3_out", dout, exp3);
         end
      end
      if (ov1 && ordy1) begin
         if (q1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL d1_extra_out: got 0x%0h required no transfer", dout1);
         end else begin
            exp1 = q1.pop_front();
            chk("d1_out", dout1, exp1);
         end
      end
   end

   task automatic drain3();
      for (int k = 0; k < 20; k++) begin
         if (q3.size() == 0) break;
         step();
      end
      chk("d3_drain_left", q3.size(), 0);
   endtask

   task automatic drain1();
      for (int k = 0; k < 20; k++) begin
         if (q1.size() == 0) break;
         step();
      end
      chk("d1_drain_left", q1.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1);
   end

   initial begin
      Rst = 1'b1;
      clr = 1'b0; en = 1'b1; iv = 1'b0; ordy = 1'b0; dclr = 8'h00; din = 8'h00;
      clr1 = 1'b0; en1 = 1'b1; iv1 = 1'b0; ordy1 = 1'b0; dclr1 = 8'h00; din1 = 8'h00;
      step();
      step();
      Rst = 1'b0;

      chk("rst_cnt", cnt, 0);
      chk("rst_dout", dout, 8'h3C);
      chk("rst_inready", ir, 1);
      chk("rst_outvalid", ov, 0);
      chk("rst1_dout", dout1, 8'hC3);
      chk("rst1_cnt", cnt1, 0);
      chk("rst1_inready", ir1, 1);

      // Streaming 0x01..0x05, output always ready
      ordy = 1'b1;
      for (int w = 1; w <= 5; w++) q3.push_back(8'(w));
      for (int i = 0; i < 8; i++) begin
         iv  = (i < 5);
         din = 8'(i + 1);
         if (i < 5) chk("t1_inready", ir, 1);
         if (i == 1 || i == 2) chk("t1_lat_ov_low", ov, 0);
         if (i == 3) begin
            chk("t1_lat_ov_high", ov, 1);
            chk("t1_peak_cnt", cnt, 3);
         end
         step();
      end
      iv = 1'b0;
      drain3();
      chk("t1_cnt_empty", cnt, 0);

      // Fill while stalled, then simultaneous pop and push when full
      ordy = 1'b0;
      q3.push_back(8'hA0); q3.push_back(8'hA1); q3.push_back(8'hA2); q3.push_back(8'hA3);
      iv = 1'b1; din = 8'hA0; step();
      din = 8'hA1; step();
      din = 8'hA2; step();
      chk("t2_full_cnt", cnt, 3);
      chk("t2_full_inready", ir, 0);
      chk("t2_full_ov", ov, 1);
      chk("t2_full_dout", dout, 8'hA0);
      din = 8'hA3; step();
      chk("t2_stall_cnt", cnt, 3);
      ordy = 1'b1;
      #1;
      chk("t2_popin_inready", ir, 1);
      step();
      chk("t2_popin_cnt", cnt, 3);
      iv = 1'b0;
      drain3();

      // Bubble collapse
      ordy = 1'b0;
      q3.push_back(8'h5A); q3.push_back(8'h5B);
      iv = 1'b1; din = 8'h5A; step();
      iv = 1'b0; step(); step();
      chk("t3_ov", ov, 1);
      chk("t3_dout", dout, 8'h5A);
      chk("t3_cnt1", cnt, 1);
      iv = 1'b1; din = 8'h5B; step();
      iv = 1'b0;
      chk("t3_cnt2", cnt, 2);
      step();
      chk("t3_cnt2_hold", cnt, 2);
      chk("t3_dout_hold", dout, 8'h5A);
      ordy = 1'b1;
      drain3();

      // Enable freeze mid-stream
      ordy = 1'b0;
      q3.push_back(8'h10); q3.push_back(8'h11);
      iv = 1'b1; din = 8'h10; step();
      din = 8'h11; step();
      iv = 1'b0; step();
      chk("t4_pre_ov", ov, 1);
      chk("t4_pre_dout", dout, 8'h10);
      en = 1'b0; ordy = 1'b1; iv = 1'b1; din = 8'h99;
      #1;
      chk("t4_frz_inready", ir, 0);
      chk("t4_frz_ov", ov, 0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t4_frz_cnt", cnt, 2);
         chk("t4_frz_dout", dout, 8'h10);
      end
      en = 1'b1; iv = 1'b0;
      drain3();

      // Clear with words in flight, then Clear while disabled
      ordy = 1'b0;
      iv = 1'b1; din = 8'h21; step();
      din = 8'h22; step();
      chk("t5_pre_cnt", cnt, 2);
      clr = 1'b1; dclr = 8'hFF; din = 8'h23; ordy = 1'b1;
      #1;
      chk("t5_clr_inready", ir, 0);
      chk("t5_clr_ov", ov, 0);
      step();
      clr = 1'b0; iv = 1'b0;
      chk("t5_cnt", cnt, 0);
      chk("t5_dout", dout, 8'hFF);
      chk("t5_ov", ov, 0);
      step(); step();
      chk("t5_cnt_after", cnt, 0);
      iv = 1'b1; din = 8'h31; step();
      iv = 1'b0;
      chk("t5_one_cnt", cnt, 1);
      en = 1'b0; clr = 1'b1; dclr = 8'h77; step();
      en = 1'b1; clr = 1'b0;
      chk("t5_dis_clr_cnt", cnt, 0);
      chk("t5_dis_clr_dout", dout, 8'h77);
      step();

      // Async reset while full
      ordy1 = 1'b0;
      iv1 = 1'b1; din1 = 8'h55; step();
      iv1 = 1'b0;
      chk("t6_d1_cnt", cnt1, 1);
      chk("t6_d1_dout", dout1, 8'h55);
      chk("t6_d1_full_inready", ir1, 0);
      ordy = 1'b0;
      iv = 1'b1; din = 8'h41; step();
      din = 8'h42; step();
      din = 8'h43; step();
      iv = 1'b0;
      chk("t6_full_cnt", cnt, 3);
      chk("t6_full_inready", ir, 0);
      Rst = 1'b1;
      #1;
      chk("t6_rst_cnt", cnt, 0);
      chk("t6_rst_dout", dout, 8'h3C);
      chk("t6_rst_d1_cnt", cnt1, 0);
      chk("t6_rst_d1_dout", dout1, 8'hC3);
      step();
      Rst = 1'b0;
      chk("t6_post_inready", ir, 1);
      chk("t6_post_ov", ov, 0);

      // DEPTH=1 streaming, one-cycle latency
      ordy1 = 1'b1;
      for (int w = 0; w < 4; w++) q1.push_back(8'(8'h61 + w));
      for (int i = 0; i < 6; i++) begin
         iv1  = (i < 4);
         din1 = 8'(8'h61 + i);
         if (i < 4) chk("t7_inready", ir1, 1);
         if (i >= 1 && i <= 4) begin
            chk("t7_ov", ov1, 1);
            chk("t7_dout", dout1, 8'h60 + i);
         end
         step();
      end
      iv1 = 1'b0;
      chk("t7_ov_empty", ov1, 0);
      q1.push_back(8'h70); q1.push_back(8'h71);
      ordy1 = 1'b0; iv1 = 1'b1; din1 = 8'h70; step();
      chk("t7_full_inready", ir1, 0);
      chk("t7_full_cnt", cnt1, 1);
      ordy1 = 1'b1; din1 = 8'h71;
      #1;
      chk("t7_popin_inready", ir1, 1);
      step();
      iv1 = 1'b0;
      chk("t7_popin_cnt", cnt1, 1);
      chk("t7_popin_dout", dout1, 8'h71);
      drain1();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
